// File: rtl/team_09_wb_regs_pkg.sv
// Shared register offsets, bus FSM state type and byte-lane helpers
// for the team_09 Wishbone register block.
package team_09_wb_regs_pkg;

  localparam logic [7:0] CTRL_OFS     = 8'h00;
  localparam logic [7:0] OUT_LO_OFS   = 8'h04;
  localparam logic [7:0] OUT_HI_OFS   = 8'h08;
  localparam logic [7:0] OEB_LO_OFS   = 8'h0C;
  localparam logic [7:0] OEB_HI_OFS   = 8'h10;
  localparam logic [7:0] IN_LO_OFS    = 8'h14;
  localparam logic [7:0] IN_HI_OFS    = 8'h18;
  localparam logic [7:0] IRQ_EN_OFS   = 8'h1C;
  localparam logic [7:0] IRQ_PEND_OFS = 8'h20;

  typedef enum logic {IDLE, ACK} wb_state_t;

  function automatic logic [31:0] byte_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

  function automatic logic [31:0] apply_sel(input logic [31:0] old_val,
                                            input logic [31:0] new_val,
                                            input logic [3:0]  sel);
    logic [31:0] m;
    m = byte_mask(sel);
    return (old_val & ~m) | (new_val & m);
  endfunction

endpackage

// File: rtl/team_09_gpio_sync.sv
// Multi-stage synchronizer for asynchronous pad inputs, plus a one-cycle
// history register so rising edges of the synced value can be flagged.
module team_09_gpio_sync #(
  parameter int WIDTH  = 34,
  parameter int STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] synced,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] chain [STAGES];
  logic [WIDTH-1:0] prev;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < STAGES; i++) chain[i] <= '0;
      prev <= '0;
    end else begin
      chain[0] <= din;
      for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
      prev <= chain[STAGES-1];
    end
  end

  assign synced = chain[STAGES-1];
  assign rise   = synced & ~prev;

endmodule

// File: rtl/team_09_wb_regs.sv
// Wishbone-classic slave exposing core enable, GPIO out/oeb/in and
// edge-triggered GPIO interrupt pending/enable registers.
//
// state | meaning
// IDLE  | waiting for cyc_i&stb_i; the access is performed on the sampling edge
// ACK   | ack_o high for this single cycle, then back to IDLE
module team_09_wb_regs
  import team_09_wb_regs_pkg::*;
#(
  parameter int NUM_GPIO    = 34,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [31:0]         adr_i,
  input  logic [31:0]         dat_i,
  input  logic [3:0]          sel_i,
  input  logic                we_i,
  input  logic                cyc_i,
  input  logic                stb_i,
  output logic                ack_o,
  output logic [31:0]         dat_o,
  input  logic [NUM_GPIO-1:0] gpio_in,
  output logic [NUM_GPIO-1:0] gpio_out,
  output logic [NUM_GPIO-1:0] gpio_oeb,
  output logic                core_en_o,
  output logic                irq_o
);

  localparam int HI_W = NUM_GPIO - 32;

  wb_state_t state, state_nxt;
  logic access, wr, rd;
  logic [7:0] ofs;
  logic [31:0] lane_mask, rd_data, pend_clr;
  logic [31:0] irq_en, irq_pend;
  logic [NUM_GPIO-1:0] gpio_synced, gpio_rise;
  logic unused_bits;

  assign ofs       = {adr_i[7:2], 2'b00};
  assign lane_mask = byte_mask(sel_i);
  assign wr        = access & we_i;
  assign rd        = access & ~we_i;
  assign ack_o     = (state == ACK);
  assign unused_bits = ^{adr_i[31:8], adr_i[1:0], gpio_rise[NUM_GPIO-1:32]};

  team_09_gpio_sync #(.WIDTH(NUM_GPIO), .STAGES(SYNC_STAGES)) u_sync (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .din    (gpio_in),
    .synced (gpio_synced),
    .rise   (gpio_rise)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    access    = 1'b0;
    case (state)
      IDLE: if (cyc_i && stb_i) begin
        access    = 1'b1;
        state_nxt = ACK;
      end
      ACK: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rd_data = '0;
    case (ofs)
      CTRL_OFS:     rd_data[0] = core_en_o;
      OUT_LO_OFS:   rd_data = gpio_out[31:0];
      OUT_HI_OFS:   rd_data[HI_W-1:0] = gpio_out[NUM_GPIO-1:32];
      OEB_LO_OFS:   rd_data = gpio_oeb[31:0];
      OEB_HI_OFS:   rd_data[HI_W-1:0] = gpio_oeb[NUM_GPIO-1:32];
      IN_LO_OFS:    rd_data = gpio_synced[31:0];
      IN_HI_OFS:    rd_data[HI_W-1:0] = gpio_synced[NUM_GPIO-1:32];
      IRQ_EN_OFS:   rd_data = irq_en;
      IRQ_PEND_OFS: rd_data = irq_pend;
      default: ;
    endcase
  end

  assign pend_clr = (wr && ofs == IRQ_PEND_OFS) ? (dat_i & lane_mask) : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      core_en_o <= 1'b0;
      gpio_out  <= '0;
      gpio_oeb  <= '1;
      irq_en    <= '0;
      irq_pend  <= '0;
      irq_o     <= 1'b0;
      dat_o     <= '0;
    end else begin
      if (wr) begin
        case (ofs)
          CTRL_OFS:   if (sel_i[0]) core_en_o <= dat_i[0];
          OUT_LO_OFS: gpio_out[31:0] <= apply_sel(gpio_out[31:0], dat_i, sel_i);
          OUT_HI_OFS: gpio_out[NUM_GPIO-1:32] <= (gpio_out[NUM_GPIO-1:32] & ~lane_mask[HI_W-1:0])
                                                | (dat_i[HI_W-1:0] & lane_mask[HI_W-1:0]);
          OEB_LO_OFS: gpio_oeb[31:0] <= apply_sel(gpio_oeb[31:0], dat_i, sel_i);
          OEB_HI_OFS: gpio_oeb[NUM_GPIO-1:32] <= (gpio_oeb[NUM_GPIO-1:32] & ~lane_mask[HI_W-1:0])
                                                | (dat_i[HI_W-1:0] & lane_mask[HI_W-1:0]);
          IRQ_EN_OFS: irq_en <= apply_sel(irq_en, dat_i, sel_i);
          default: ;
        endcase
      end
      // A new edge overrides a same-cycle write-1-clear on that bit.
      irq_pend <= (irq_pend & ~pend_clr) | gpio_rise[31:0];
      irq_o    <= |(irq_pend & irq_en);
      if (rd) dat_o <= rd_data;
    end
  end

endmodule

// File: tb/tb_team_09_wb_regs.sv
// Self-checking bench for team_09_wb_regs: directed table, hand-written
// corner sequences, then random traffic against a register-level model.
module tb_team_09_wb_regs;

  logic        clk_i = 1'b0;
  logic        rst_i, we_i, cyc_i, stb_i;
  logic        ack_o, core_en_o, irq_o;
  logic [31:0] adr_i, dat_i, dat_o;
  logic [3:0]  sel_i;
  logic [33:0] gpio_in, gpio_out, gpio_oeb;

  int tests = 0;
  int fails = 0;

  // reference model state
  logic        m_ctrl;
  logic [33:0] m_out, m_oeb, m_pad;
  logic [31:0] m_en, m_pend;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    logic [31:0] rexp;
  } vec_t;
  vec_t vecs[10];

  always #5 clk_i = ~clk_i;

  team_09_wb_regs #(.NUM_GPIO(34), .SYNC_STAGES(2)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .adr_i     (adr_i),
    .dat_i     (dat_i),
    .sel_i     (sel_i),
    .we_i      (we_i),
    .cyc_i     (cyc_i),
    .stb_i     (stb_i),
    .ack_o     (ack_o),
    .dat_o     (dat_o),
    .gpio_in   (gpio_in),
    .gpio_out  (gpio_out),
    .gpio_oeb  (gpio_oeb),
    .core_en_o (core_en_o),
    .irq_o     (irq_o)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic wb_access(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic w, output logic [31:0] rdata);
    int lat;
    adr_i = a; dat_i = d; sel_i = s; we_i = w; cyc_i = 1'b1; stb_i = 1'b1;
    lat = 0;
    do begin
      tick(1);
      lat++;
    end while (!ack_o && lat < 8);
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    check("ack_latency", 64'(lat), 64'd1);
    rdata = dat_o;
    tick(1);
    check("ack_single_cycle", 64'(ack_o), 64'd0);
  endtask

  task automatic do_reset;
    rst_i = 1'b1; cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    tick(3);
    rst_i = 1'b0;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic void m_write(input logic [7:0] o, input logic [31:0] d, input logic [3:0] s);
    case (o)
      8'h00: if (s[0]) m_ctrl = d[0];
      8'h04: m_out[31:0] = merge(m_out[31:0], d, s);
      8'h08: if (s[0]) m_out[33:32] = d[1:0];
      8'h0C: m_oeb[31:0] = merge(m_oeb[31:0], d, s);
      8'h10: if (s[0]) m_oeb[33:32] = d[1:0];
      8'h1C: m_en = merge(m_en, d, s);
      8'h20: m_pend = m_pend & ~merge(32'h0, d, s);
      default: ;
    endcase
  endfunction

  function automatic logic [31:0] m_read(input logic [7:0] o);
    case (o)
      8'h00:   return {31'b0, m_ctrl};
      8'h04:   return m_out[31:0];
      8'h08:   return {30'b0, m_out[33:32]};
      8'h0C:   return m_oeb[31:0];
      8'h10:   return {30'b0, m_oeb[33:32]};
      8'h14:   return m_pad[31:0];
      8'h18:   return {30'b0, m_pad[33:32]};
      8'h1C:   return m_en;
      8'h20:   return m_pend;
      default: return 32'h0;
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;
    logic [5:0]  pattern;
    logic [7:0]  offs [12];

    adr_i = '0; dat_i = '0; sel_i = '0; gpio_in = '0; rst_i = 1'b1;
    we_i = 1'b0; cyc_i = 1'b0; stb_i = 1'b0;
    do_reset();

    check("rst_ack", 64'(ack_o), 64'd0);
    check("rst_oeb", 64'(gpio_oeb), 64'h3_FFFF_FFFF);
    check("rst_out", 64'(gpio_out), 64'd0);
    check("rst_irq", 64'(irq_o), 64'd0);
    check("rst_dat", 64'(dat_o), 64'd0);
    check("rst_core_en", 64'(core_en_o), 64'd0);

    vecs[0] = '{32'h00, 32'hFFFF_FFFF, 4'hF, 32'h0000_0001};
    vecs[1] = '{32'h04, 32'hDEAD_BEEF, 4'b0101, 32'h00AD_00EF};
    vecs[2] = '{32'h08, 32'hFFFF_FFFF, 4'hF, 32'h0000_0003};
    vecs[3] = '{32'h0C, 32'h1234_5678, 4'b1000, 32'h12FF_FFFF};
    vecs[4] = '{32'h10, 32'h0000_0000, 4'b0001, 32'h0000_0000};
    vecs[5] = '{32'h1C, 32'hA5A5_A5A5, 4'b0011, 32'h0000_A5A5};
    vecs[6] = '{32'h14, 32'hFFFF_FFFF, 4'hF, 32'h0000_0000};
    vecs[7] = '{32'h20, 32'hFFFF_FFFF, 4'hF, 32'h0000_0000};
    vecs[8] = '{32'h24, 32'hFFFF_FFFF, 4'hF, 32'h0000_0000};
    vecs[9] = '{32'h3C, 32'hFFFF_FFFF, 4'hF, 32'h0000_0000};
    for (int i = 0; i < 10; i++) begin
      wb_access(vecs[i].adr, vecs[i].wdata, vecs[i].sel, 1'b1, rd);
      wb_access(vecs[i].adr, 32'h0, 4'h0, 1'b0, rd);
      check($sformatf("vec%0d_read", i), 64'(rd), 64'(vecs[i].rexp));
    end
    check("vec_gpio_out", 64'(gpio_out), 64'h3_00AD_00EF);
    check("vec_gpio_oeb", 64'(gpio_oeb), 64'h0_12FF_FFFF);
    check("vec_core_en", 64'(core_en_o), 64'd1);

    // strobe held continuously: one access every two cycles
    wb_access(32'h00, 32'h0, 4'hF, 1'b1, rd);
    check("ctrl_cleared", 64'(core_en_o), 64'd0);
    adr_i = 32'h00; dat_i = 32'h1; sel_i = 4'hF; we_i = 1'b1; cyc_i = 1'b1; stb_i = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick(1);
      pattern[c] = ack_o;
      if (c == 0) check("hold_core_en", 64'(core_en_o), 64'd1);
    end
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    tick(1);
    check("hold_ack_pattern", 64'(pattern), 64'b010101);

    // interrupt path: sync delay, pending set, registered irq, W1C
    wb_access(32'h1C, 32'h8, 4'hF, 1'b1, rd);
    gpio_in[3] = 1'b1;
    tick(1);
    wb_access(32'h14, 32'h0, 4'h0, 1'b0, rd);
    check("in_lo_not_yet", 64'(rd), 64'h0);
    check("irq_not_yet", 64'(irq_o), 64'd0);
    tick(1);
    check("irq_set", 64'(irq_o), 64'd1);
    gpio_in[6] = 1'b1;
    tick(1);
    wb_access(32'h14, 32'h0, 4'h0, 1'b0, rd);
    check("in_lo_bit3", 64'(rd), 64'h8);
    wb_access(32'h14, 32'h0, 4'h0, 1'b0, rd);
    check("in_lo_bit3_6", 64'(rd), 64'h48);
    wb_access(32'h20, 32'h0, 4'h0, 1'b0, rd);
    check("pend_read", 64'(rd), 64'h48);
    wb_access(32'h20, 32'h8, 4'hF, 1'b1, rd);
    check("irq_cleared", 64'(irq_o), 64'd0);

    // W1C colliding with a fresh edge on the same bit
    gpio_in[5] = 1'b1;
    tick(2);
    wb_access(32'h20, 32'h20, 4'hF, 1'b1, rd);
    wb_access(32'h20, 32'h0, 4'h0, 1'b0, rd);
    check("w1c_vs_edge", 64'(rd), 64'h60);

    // reset asserted on the IDLE sampling edge of a write
    adr_i = 32'h08; dat_i = 32'h3; sel_i = 4'hF; we_i = 1'b1; cyc_i = 1'b1; stb_i = 1'b1;
    rst_i = 1'b1;
    tick(1);
    check("rst_idle_no_ack", 64'(ack_o), 64'd0);
    rst_i = 1'b0; cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    tick(1);
    check("rst_idle_no_ack2", 64'(ack_o), 64'd0);
    check("rst_idle_out_hi", 64'(gpio_out[33:32]), 64'd0);
    wb_access(32'h3C, 32'h0, 4'h0, 1'b0, rd);
    check("unmapped_read", 64'(rd), 64'h0);

    // reset arriving while ack is high
    adr_i = 32'h04; dat_i = 32'hFFFF; sel_i = 4'hF; we_i = 1'b1; cyc_i = 1'b1; stb_i = 1'b1;
    tick(1);
    check("ack_before_rst", 64'(ack_o), 64'd1);
    rst_i = 1'b1; cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    tick(1);
    rst_i = 1'b0;
    check("rst_ack_dropped", 64'(ack_o), 64'd0);
    check("rst_ack_out", 64'(gpio_out), 64'd0);
    check("rst_ack_oeb", 64'(gpio_oeb), 64'h3_FFFF_FFFF);

    // random traffic against the model
    gpio_in = '0;
    do_reset();
    m_ctrl = 1'b0; m_out = '0; m_oeb = '1; m_pad = '0; m_en = '0; m_pend = '0;
    offs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C, 8'h20, 8'h24, 8'h3C, 8'h80};
    for (int it = 0; it < 300; it++) begin
      if ($urandom_range(0, 5) == 0) begin
        logic [63:0] r64;
        r64 = {$urandom, $urandom};
        m_pend = m_pend | (r64[31:0] & ~m_pad[31:0]);
        m_pad = r64[33:0];
        gpio_in = r64[33:0];
        tick(4);
      end else begin
        logic [31:0] r, a, d;
        logic [7:0]  o;
        logic        w;
        logic [3:0]  s;
        r = $urandom;
        o = offs[$urandom_range(0, 11)];
        a = {r[31:8], o[7:2], r[1:0]};
        d = $urandom;
        s = 4'($urandom_range(0, 15));
        w = 1'($urandom_range(0, 1));
        wb_access(a, d, s, w, rd);
        if (w) m_write(o, d, s);
        else check($sformatf("rand_read_%02h", o), 64'(rd), 64'(m_read(o)));
      end
      check("rand_out", 64'(gpio_out), 64'(m_out));
      check("rand_oeb", 64'(gpio_oeb), 64'(m_oeb));
      check("rand_core_en", 64'(core_en_o), 64'(m_ctrl));
      check("rand_irq", 64'(irq_o), 64'(|(m_pend & m_en)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
